// File: rtl/unit_nto_m.sv
// Binary-weight neuron layer: XNOR-majority forward/backward paths with
// per-weight saturating gradient accumulators that flip a weight at THRESH.
module unit_nto_m #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int ACC_W  = 4,
  parameter int THRESH = 8,
  parameter logic [N_IN*N_OUT-1:0] INIT_W = '0,
  localparam int NW    = N_IN * N_OUT,
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             oscillator,
  input  logic             fd_prop,
  input  logic             bk_prop,
  input  logic             learn_en,
  input  logic [N_IN-1:0]  fin,
  input  logic [N_OUT-1:0] bin,
  input  logic             w_wr_en,
  input  logic [IDX_W-1:0] w_wr_idx,
  input  logic             w_wr_val,
  output logic [NW-1:0]    control_out,
  output logic [N_OUT-1:0] fout,
  output logic [N_IN-1:0]  bout,
  output logic             flip_out
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  localparam logic [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic [NW-1:0]                w_q, w_d;
  logic [NW-1:0][ACC_W-1:0]     acc_q, acc_d;
  logic [N_IN-1:0]              fin_q, fin_d;
  logic [N_OUT-1:0]             fout_q, fout_d;
  logic [N_IN-1:0]              bout_q, bout_d;
  logic                         flip_q, flip_d;
  // per weight: {flip, next weight, next accumulator} from the gradient rule
  logic [NW-1:0][ACC_W+1:0]     step_s;

  function automatic logic vote(input int agree, input int n, input logic tie);
    if (2 * agree > n) return 1'b1;
    else if (2 * agree == n) return tie;
    else return 1'b0;
  endfunction

  function automatic int fwd_agree(input logic [N_IN-1:0] x, input logic [NW-1:0] w, input int j);
    int c = 0;
    for (int i = 0; i < N_IN; i++) if (x[i] == w[j*N_IN+i]) c++;
    return c;
  endfunction

  function automatic int bwd_agree(input logic [N_OUT-1:0] b, input logic [NW-1:0] w, input int i);
    int c = 0;
    for (int j = 0; j < N_OUT; j++) if (b[j] == w[j*N_IN+i]) c++;
    return c;
  endfunction

  function automatic logic [ACC_W+1:0] grad_step(input logic [ACC_W-1:0] acc, input logic w,
                                                 input logic x, input logic b);
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] acc_n;
    logic             w_n;
    logic             flip;
    inc  = (acc == ACC_MAX) ? ACC_MAX : acc + ACC_ONE;
    w_n  = w;
    flip = 1'b0;
    if ((x ~^ w) != b) begin
      if (int'(inc) >= THRESH) begin
        w_n   = ~w;
        acc_n = '0;
        flip  = 1'b1;
      end else begin
        acc_n = inc;
      end
    end else begin
      acc_n = (acc == '0) ? '0 : acc - ACC_ONE;
    end
    return {flip, w_n, acc_n};
  endfunction

  // Forward and backward vote outputs, using the weights before any flip
  always_comb begin
    fout_d = fout_q;
    bout_d = bout_q;
    fin_d  = fin_q;
    if (fd_prop) begin
      fin_d = fin;
      for (int j = 0; j < N_OUT; j++) fout_d[j] = vote(fwd_agree(fin, w_q, j), N_IN, oscillator);
    end else begin
      fin_d = fin_q;
    end
    if (bk_prop) begin
      for (int i = 0; i < N_IN; i++) bout_d[i] = vote(bwd_agree(bin, w_q, i), N_OUT, oscillator);
    end else begin
      bout_d = bout_q;
    end
  end

  // Gradient rule per weight; uses fin_q from before any same-cycle forward strobe
  always_comb begin
    step_s = '0;
    for (int k = 0; k < NW; k++) begin
      if (bk_prop && learn_en) step_s[k] = grad_step(acc_q[k], w_q[k], fin_q[k % N_IN], bin[k / N_IN]);
      else step_s[k] = {1'b0, w_q[k], acc_q[k]};
    end
  end

  // External write overrides the learning result for its index
  always_comb begin
    w_d    = w_q;
    acc_d  = acc_q;
    flip_d = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (w_wr_en && (int'(w_wr_idx) == k)) begin
        w_d[k]   = w_wr_val;
        acc_d[k] = '0;
      end else begin
        w_d[k]   = step_s[k][ACC_W];
        acc_d[k] = step_s[k][ACC_W-1:0];
        flip_d   = flip_d | step_s[k][ACC_W+1];
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      w_q    <= INIT_W;
      acc_q  <= '0;
      fin_q  <= '0;
      fout_q <= '0;
      bout_q <= '0;
      flip_q <= 1'b0;
    end else begin
      w_q    <= w_d;
      acc_q  <= acc_d;
      fin_q  <= fin_d;
      fout_q <= fout_d;
      bout_q <= bout_d;
      flip_q <= flip_d;
    end
  end

  assign control_out = w_q;
  assign fout        = fout_q;
  assign bout        = bout_q;
  assign flip_out    = flip_q;

endmodule

// File: tb/tb_unit_nto_m.sv
// Directed bench for unit_nto_m: expected values queued at stimulus time,
// popped and compared after each clock edge.
module tb_unit_nto_m;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic osc = 1'b0;
  always #5 clk = ~clk;

  // instance A: 3 inputs x 2 outputs, THRESH=2, INIT_W=101010
  logic       a_fd = 1'b0, a_bk = 1'b0, a_learn = 1'b0, a_wen = 1'b0, a_wval = 1'b0;
  logic [2:0] a_fin = '0, a_widx = '0;
  logic [1:0] a_bin = '0;
  logic [5:0] a_ctrl;
  logic [1:0] a_fout;
  logic [2:0] a_bout;
  logic       a_flip;

  // instance B: 4 inputs x 2 outputs, ACC_W=2, THRESH=3
  logic       b_fd = 1'b0, b_bk = 1'b0, b_learn = 1'b0, b_wen = 1'b0, b_wval = 1'b0;
  logic [3:0] b_fin = '0;
  logic [2:0] b_widx = '0;
  logic [1:0] b_bin = '0;
  logic [7:0] b_ctrl;
  logic [1:0] b_fout;
  logic [3:0] b_bout;
  logic       b_flip;

  unit_nto_m #(.N_IN(3), .N_OUT(2), .ACC_W(4), .THRESH(2), .INIT_W(6'b101010)) u_a (
    .clk_in(clk), .rst_in(rst), .oscillator(osc), .fd_prop(a_fd), .bk_prop(a_bk),
    .learn_en(a_learn), .fin(a_fin), .bin(a_bin), .w_wr_en(a_wen), .w_wr_idx(a_widx),
    .w_wr_val(a_wval), .control_out(a_ctrl), .fout(a_fout), .bout(a_bout), .flip_out(a_flip)
  );

  unit_nto_m #(.N_IN(4), .N_OUT(2), .ACC_W(2), .THRESH(3), .INIT_W(8'h00)) u_b (
    .clk_in(clk), .rst_in(rst), .oscillator(osc), .fd_prop(b_fd), .bk_prop(b_bk),
    .learn_en(b_learn), .fin(b_fin), .bin(b_bin), .w_wr_en(b_wen), .w_wr_idx(b_widx),
    .w_wr_val(b_wval), .control_out(b_ctrl), .fout(b_fout), .bout(b_bout), .flip_out(b_flip)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_err = 0;
  int  n_chk = 0;

  task automatic expect_v(input string tag, input logic [31:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic check_v(input logic [31:0] obs);
    sb_t it;
    n_chk++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%0h expected=<queued entry>", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state while rst is held
    tick; tick;
    expect_v("rst_ctrl", 32'h2A); expect_v("rst_fout", 32'h0);
    expect_v("rst_bout", 32'h0);  expect_v("rst_flip", 32'h0); expect_v("rst_b_ctrl", 32'h0);
    check_v(32'(a_ctrl)); check_v(32'(a_fout)); check_v(32'(a_bout));
    check_v(32'(a_flip)); check_v(32'(b_ctrl));
    rst = 1'b0;
    tick;

    // forward with INIT_W weights, then a write, then asynchronous reset mid-cycle
    a_fin = 3'b111; a_fd = 1'b1; expect_v("fwd_init", 32'h2);
    tick; a_fd = 1'b0; check_v(32'(a_fout));
    a_wen = 1'b1; a_widx = 3'd1; a_wval = 1'b0; expect_v("wr_k1", 32'h28);
    tick; a_wen = 1'b0; check_v(32'(a_ctrl));
    a_fin = 3'b111; a_fd = 1'b1;
    #3 rst = 1'b1;
    #1;
    expect_v("async_ctrl", 32'h2A); expect_v("async_fout", 32'h0);
    expect_v("async_bout", 32'h0);  expect_v("async_flip", 32'h0);
    check_v(32'(a_ctrl)); check_v(32'(a_fout)); check_v(32'(a_bout)); check_v(32'(a_flip));
    expect_v("rst_discard_fd", 32'h0);
    tick; check_v(32'(a_fout));
    rst = 1'b0; a_fd = 1'b0;
    tick;

    // clear the set weights so all are zero
    a_wen = 1'b1; a_wval = 1'b0;
    for (int k = 1; k < 6; k += 2) begin
      a_widx = 3'(k);
      tick;
    end
    a_wen = 1'b0;
    expect_v("zero_ctrl", 32'h0); check_v(32'(a_ctrl));

    // forward patterns
    a_fin = 3'b000; a_fd = 1'b1; expect_v("fwd_000", 32'h3);
    tick; a_fd = 1'b0; check_v(32'(a_fout));
    a_fin = 3'b011; a_fd = 1'b1; expect_v("fwd_011", 32'h0);
    tick; a_fd = 1'b0; check_v(32'(a_fout));

    // backward with learning disabled while errors are present
    a_bin = 2'b00; a_bk = 1'b1; a_learn = 1'b0;
    expect_v("nolearn_bout", 32'h7); expect_v("nolearn_flip", 32'h0); expect_v("nolearn_ctrl", 32'h0);
    tick; a_bk = 1'b0; check_v(32'(a_bout)); check_v(32'(a_flip)); check_v(32'(a_ctrl));

    // learning: two all-error strobes flip every weight
    a_fin = 3'b111; a_fd = 1'b1; expect_v("fwd_111", 32'h0);
    tick; a_fd = 1'b0; check_v(32'(a_fout));
    a_bin = 2'b11; a_bk = 1'b1; a_learn = 1'b1;
    expect_v("learn1_bout", 32'h0); expect_v("learn1_flip", 32'h0); expect_v("learn1_ctrl", 32'h0);
    tick; check_v(32'(a_bout)); check_v(32'(a_flip)); check_v(32'(a_ctrl));
    expect_v("learn2_bout", 32'h0); expect_v("learn2_flip", 32'h1); expect_v("learn2_ctrl", 32'h3F);
    tick; a_bk = 1'b0; check_v(32'(a_bout)); check_v(32'(a_flip)); check_v(32'(a_ctrl));
    expect_v("flip_pulse_end", 32'h0); expect_v("hold_ctrl", 32'h3F);
    tick; check_v(32'(a_flip)); check_v(32'(a_ctrl));

    // accumulators restarted from 0: one error does not flip
    a_bin = 2'b00; a_bk = 1'b1;
    expect_v("acc_clr_flip", 32'h0); expect_v("acc_clr_ctrl", 32'h3F);
    tick; check_v(32'(a_flip)); check_v(32'(a_ctrl));

    // write collides with flip on k=4; others flip
    a_wen = 1'b1; a_widx = 3'd4; a_wval = 1'b1;
    expect_v("coll_flip", 32'h1); expect_v("coll_ctrl", 32'h10);
    tick; a_wen = 1'b0; check_v(32'(a_flip)); check_v(32'(a_ctrl));
    expect_v("coll_acc_clr_flip", 32'h0); expect_v("coll_acc_clr_ctrl", 32'h10);
    tick; check_v(32'(a_flip)); check_v(32'(a_ctrl));
    // only flip candidate is suppressed by the write
    a_wen = 1'b1; a_widx = 3'd4; a_wval = 1'b1;
    expect_v("coll_only_flip", 32'h0); expect_v("coll_only_ctrl", 32'h10);
    tick; a_wen = 1'b0; a_bk = 1'b0; check_v(32'(a_flip)); check_v(32'(a_ctrl));

    // out-of-range write indices are ignored
    a_wen = 1'b1; a_wval = 1'b1; a_widx = 3'd6;
    tick; a_widx = 3'd7;
    tick; a_wen = 1'b0;
    expect_v("oor_ctrl", 32'h10); check_v(32'(a_ctrl));

    // fd_prop and bk_prop together: gradient uses the old fin_q
    a_fin = 3'b000; a_fd = 1'b1; expect_v("fwd_pre", 32'h3);
    tick; a_fd = 1'b0; check_v(32'(a_fout));
    osc = 1'b0; a_fin = 3'b111; a_fd = 1'b1; a_bin = 2'b00; a_bk = 1'b1; a_learn = 1'b1;
    expect_v("both_fout", 32'h0); expect_v("both_bout_tie0", 32'h5);
    expect_v("both_flip", 32'h0); expect_v("both_ctrl", 32'h10);
    tick; a_fd = 1'b0;
    check_v(32'(a_fout)); check_v(32'(a_bout)); check_v(32'(a_flip)); check_v(32'(a_ctrl));
    osc = 1'b1; a_bin = 2'b10;
    expect_v("oldfinq_bout_tie1", 32'h7); expect_v("oldfinq_flip", 32'h1); expect_v("oldfinq_ctrl", 32'h38);
    tick; a_bk = 1'b0;
    check_v(32'(a_bout)); check_v(32'(a_flip)); check_v(32'(a_ctrl));
    expect_v("oldfinq_pulse_end", 32'h0);
    tick; check_v(32'(a_flip));

    // instance B: even N_IN ties resolve to the oscillator
    b_fin = 4'b0011; osc = 1'b1; b_fd = 1'b1; expect_v("tie_osc1", 32'h3);
    tick; check_v(32'(b_fout));
    osc = 1'b0; expect_v("tie_osc0", 32'h0);
    tick; check_v(32'(b_fout));
    b_fin = 4'b0000; expect_v("b_fwd_0000", 32'h3);
    tick; b_fd = 1'b0; check_v(32'(b_fout));

    // alternating error/no-error never reaches THRESH
    b_bk = 1'b1; b_learn = 1'b1;
    for (int n = 0; n < 6; n++) begin
      b_bin = (n % 2 == 0) ? 2'b00 : 2'b11;
      expect_v("alt_flip", 32'h0);
      tick; check_v(32'(b_flip));
    end
    // repeated no-error must not wrap below zero
    b_bin = 2'b11;
    for (int n = 0; n < 3; n++) begin
      expect_v("decay_flip", 32'h0);
      tick; check_v(32'(b_flip));
    end
    // exactly three errors from zero are needed to flip
    b_bin = 2'b00;
    expect_v("rise1_flip", 32'h0);
    tick; check_v(32'(b_flip));
    expect_v("rise2_flip", 32'h0); expect_v("rise2_ctrl", 32'h00);
    tick; check_v(32'(b_flip)); check_v(32'(b_ctrl));
    expect_v("rise3_flip", 32'h1); expect_v("rise3_ctrl", 32'hFF);
    tick; b_bk = 1'b0; check_v(32'(b_flip)); check_v(32'(b_ctrl));

    if (sb.size() != 0) begin
      n_chk++;
      n_err++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
